// File: rtl/s1_fetch.sv
// ----------------------------------------------------------------------------
// s1_fetch -- stage-1 instruction fetch for the 3-stage RV32I pipeline.
//
// Owns the PC register and selects the next PC from the stage-3 pc_sel code.
// It drives the word addresses of the synchronous-read BIOS and IMEM from
// pc_next, so the returned word on *_dout always belongs to pc_s1. It then
// registers {inst, pc, valid} into the s1->s2 pipeline register. On a redirect,
// the wrong-path word is replaced by a NOP bubble.
//
// Optional feature macro: FETCH_PERF_EN
//   defined   : fetch_count / flush_count performance counters are present
//   undefined : no counter registers; both outputs are tied to zero
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   stall               hold PC and the s2 register (memory-side stall)
//   pc_sel              0:pc+4 1:alu_target 2:jal_target 3:RESET_PC
//   alu_target          branch/JALR target from the stage-2 ALU
//   jal_target          JAL target from the stage-2 adder
//   bios_addr/imem_addr word addresses derived from pc_next
//   bios_dout/imem_dout read data, one cycle after the address
//   pc_s1               PC whose word is currently on *_dout
//   inst_s2/pc_s2       instruction and its PC into stage 2
//   valid_s2            inst_s2 is a real instruction (not a bubble)
//   fetch_count         words loaded into s2 with valid_s2=1
//   flush_count         redirect edges
// ----------------------------------------------------------------------------
module s1_fetch #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          IMEM_AW  = 14,
  parameter int          BIOS_AW  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [1:0]         pc_sel,
  input  logic [31:0]        alu_target,
  input  logic [31:0]        jal_target,
  output logic [BIOS_AW-1:0] bios_addr,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        bios_dout,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        pc_s1,
  output logic [31:0]        inst_s2,
  output logic [31:0]        pc_s2,
  output logic               valid_s2,
  output logic [31:0]        fetch_count,
  output logic [31:0]        flush_count
);

  // Pick the returned word by the region of the PC it was fetched for.
  // Regions other than BIOS (01) and IMEM (00) have no instruction memory.
  function automatic logic [31:0] region_word(input logic [31:0] pc,
                                              input logic [31:0] bios_w,
                                              input logic [31:0] imem_w);
    case (pc[31:30])
      2'b01:   return bios_w;
      2'b00:   return imem_w;
      default: return NOP_INST;
    endcase
  endfunction

  logic [31:0] pc_q,    pc_d;
  logic [31:0] inst_q,  inst_d;
  logic [31:0] pcs2_q,  pcs2_d;
  logic        vld_q,   vld_d;
  logic        redirect;
  logic [31:0] word;

  assign redirect = (pc_sel != 2'd0);
  assign word     = region_word(pc_q, bios_dout, imem_dout);

  // Next-PC selection. A redirect beats stall; stall alone re-presents the
  // current PC so the memories return the same word again next cycle.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (rst) begin
      pc_d = RESET_PC;
    end else begin
      case (pc_sel)
        2'd3:    pc_d = RESET_PC;
        2'd2:    pc_d = jal_target;
        2'd1:    pc_d = alu_target;
        default: pc_d = stall ? pc_q : pc_q + 32'd4;
      endcase
    end
  end

  // Addresses come from pc_next so the 1-cycle memory latency lines the
  // returned word up with pc_s1. Low two bits are dropped (word addressing),
  // so misaligned targets still fetch the containing word.
  assign bios_addr = pc_d[BIOS_AW+1:2];
  assign imem_addr = pc_d[IMEM_AW+1:2];

  // s2 register next state: reset, then squash on redirect, then hold on stall.
  always_comb begin
    inst_d = word;
    pcs2_d = pc_q;
    vld_d  = 1'b1;
    if (rst) begin
      inst_d = NOP_INST;
      pcs2_d = 32'h0;
      vld_d  = 1'b0;
    end else if (redirect) begin
      inst_d = NOP_INST;
      pcs2_d = pc_q;
      vld_d  = 1'b0;
    end else if (stall) begin
      inst_d = inst_q;
      pcs2_d = pcs2_q;
      vld_d  = vld_q;
    end
  end

  // ---- s1 -> s2 boundary ----
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    inst_q <= inst_d;
    pcs2_q <= pcs2_d;
    vld_q  <= vld_d;
  end

  assign pc_s1    = pc_q;
  assign inst_s2  = inst_q;
  assign pc_s2    = pcs2_q;
  assign valid_s2 = vld_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Count exactly the edges that load a valid word, and the redirect edges.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rst) begin
      fetch_cnt_d = 32'h0;
      flush_cnt_d = 32'h0;
    end else if (redirect) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (!stall) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    fetch_cnt_q <= fetch_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign fetch_count = 32'h0;
  assign flush_count = 32'h0;
`endif

endmodule

// File: tb/tb_s1_fetch.sv
module tb_s1_fetch;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  pc_sel = 2'd0;
  logic [31:0] alu_target = 32'h0;
  logic [31:0] jal_target = 32'h0;
  logic [11:0] bios_addr;
  logic [13:0] imem_addr;
  logic [31:0] bios_dout;
  logic [31:0] imem_dout;
  logic [31:0] pc_s1, inst_s2, pc_s2, fetch_count, flush_count;
  logic        valid_s2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  s1_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel),
    .alu_target(alu_target), .jal_target(jal_target),
    .bios_addr(bios_addr), .imem_addr(imem_addr),
    .bios_dout(bios_dout), .imem_dout(imem_dout),
    .pc_s1(pc_s1), .inst_s2(inst_s2), .pc_s2(pc_s2), .valid_s2(valid_s2),
    .fetch_count(fetch_count), .flush_count(flush_count)
  );

  // Memory contents: each word encodes its own address and memory.
  function automatic logic [31:0] bios_word(input logic [11:0] a);
    if (a == 12'h0) return 32'h0010_0093;
    return {4'hB, 16'h0, a};
  endfunction
  function automatic logic [31:0] imem_word(input logic [13:0] a);
    return {4'h1, 14'h0, a};
  endfunction

  // Synchronous-read memories, 1-cycle latency.
  always @(posedge clk) begin
    bios_dout <= bios_word(bios_addr);
    imem_dout <= imem_word(imem_addr);
  end

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc, m_inst, m_s2pc, m_fetch, m_flush;
  logic        m_vld;
  logic [11:0] m_baddr, cap_baddr;
  logic [13:0] m_iaddr, cap_iaddr;

  // Instruction a PC should fetch, by address map.
  function automatic logic [31:0] m_word(input logic [31:0] pc);
    if (pc[31:30] == 2'b01) return bios_word(pc[13:2]);
    if (pc[31:30] == 2'b00) return imem_word(pc[15:2]);
    return NOP_INST;
  endfunction

  task automatic step(input logic r, input logic st, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] jal);
    logic [31:0] nxt;
    logic [31:0] w;
    @(negedge clk);
    rst = r; stall = st; pc_sel = sel; alu_target = alu; jal_target = jal;
    if (r || sel == 2'd3) nxt = RESET_PC;
    else if (sel == 2'd2) nxt = jal;
    else if (sel == 2'd1) nxt = alu;
    else if (st)          nxt = m_pc;
    else                  nxt = m_pc + 32'd4;
    m_baddr = nxt[13:2];
    m_iaddr = nxt[15:2];
    w = m_word(m_pc);
    #1;
    cap_baddr = bios_addr;
    cap_iaddr = imem_addr;
    @(posedge clk);
    if (r) begin
      m_inst = NOP_INST; m_s2pc = 32'h0; m_vld = 1'b0; m_fetch = 0; m_flush = 0;
    end else if (sel != 2'd0) begin
      m_inst = NOP_INST; m_s2pc = m_pc; m_vld = 1'b0; m_flush = m_flush + 1;
    end else if (!st) begin
      m_inst = w; m_s2pc = m_pc; m_vld = 1'b1; m_fetch = m_fetch + 1;
    end
    m_pc = nxt;
    #1;
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom;
    case ($urandom_range(0, 3))
      0:       t[31:30] = 2'b00;
      1, 2:    t[31:30] = 2'b01;
      default: t[31:30] = 2'b11;
    endcase
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 2'($urandom), $urandom, $urandom);
    tests++; if (pc_s1 !== RESET_PC) begin failed++; $display("FAIL reset_pc got %h exp %h", pc_s1, RESET_PC); end
    tests++; if (inst_s2 !== NOP_INST) begin failed++; $display("FAIL reset_inst got %h exp %h", inst_s2, NOP_INST); end
    tests++; if (pc_s2 !== 32'h0) begin failed++; $display("FAIL reset_pc_s2 got %h exp 0", pc_s2); end
    tests++; if (valid_s2 !== 1'b0) begin failed++; $display("FAIL reset_valid got %b exp 0", valid_s2); end
    tests++; if (fetch_count !== 32'h0 || flush_count !== 32'h0) begin failed++; $display("FAIL reset_counters got %h/%h exp 0/0", fetch_count, flush_count); end
    tests++; if (cap_baddr !== 12'h0) begin failed++; $display("FAIL reset_bios_addr got %h exp 0", cap_baddr); end
  endtask

  task automatic test_first_fetch();
    step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tests++; if (cap_baddr !== 12'h1) begin failed++; $display("FAIL ff_addr1 got %h exp 1", cap_baddr); end
    tests++; if (inst_s2 !== 32'h0010_0093 || pc_s2 !== RESET_PC || valid_s2 !== 1'b1) begin
      failed++; $display("FAIL ff_s2 got %h/%h/%b exp 00100093/40000000/1", inst_s2, pc_s2, valid_s2); end
    step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tests++; if (cap_baddr !== 12'h2) begin failed++; $display("FAIL ff_addr2 got %h exp 2", cap_baddr); end
    tests++; if (inst_s2 !== bios_word(12'h1) || pc_s2 !== 32'h4000_0004) begin
      failed++; $display("FAIL ff_second got %h/%h exp %h/40000004", inst_s2, pc_s2, bios_word(12'h1)); end
  endtask

  task automatic test_branch_redirect();
    logic [31:0] pc_before;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tests++; if (valid_s2 !== 1'b1 || inst_s2 !== m_inst) begin failed++; $display("FAIL br_seq got %h/%b exp %h/1", inst_s2, valid_s2, m_inst); end
    pc_before = pc_s1;
    step(1'b0, 1'b0, 2'd1, 32'h1000_0010, 32'h0);
    tests++; if (inst_s2 !== NOP_INST || valid_s2 !== 1'b0 || pc_s2 !== pc_before) begin
      failed++; $display("FAIL br_bubble got %h/%h/%b exp %h/%h/0", inst_s2, pc_s2, valid_s2, NOP_INST, pc_before); end
    tests++; if (cap_iaddr !== 14'h4) begin failed++; $display("FAIL br_imem_addr got %h exp 4", cap_iaddr); end
    step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tests++; if (inst_s2 !== 32'h1000_0004 || pc_s2 !== 32'h1000_0010 || valid_s2 !== 1'b1) begin
      failed++; $display("FAIL br_target got %h/%h/%b exp 10000004/10000010/1", inst_s2, pc_s2, valid_s2); end
  endtask

  task automatic test_jal_stall();
    logic [31:0] hi, hp;
    step(1'b0, 1'b1, 2'd2, 32'h0, 32'h4000_0100);
    tests++; if (pc_s1 !== 32'h4000_0100 || valid_s2 !== 1'b0 || inst_s2 !== NOP_INST) begin
      failed++; $display("FAIL jal_stall got %h/%h/%b exp 40000100/%h/0", pc_s1, inst_s2, valid_s2, NOP_INST); end
    hi = inst_s2; hp = pc_s2;
    step(1'b0, 1'b1, 2'd0, 32'h0, 32'h0);
    tests++; if (inst_s2 !== hi || pc_s2 !== hp || valid_s2 !== 1'b0 || pc_s1 !== 32'h4000_0100) begin
      failed++; $display("FAIL stall_hold got %h/%h/%b/%h exp %h/%h/0/40000100", inst_s2, pc_s2, valid_s2, pc_s1, hi, hp); end
    tests++; if (cap_baddr !== 12'h040) begin failed++; $display("FAIL stall_addr got %h exp 040", cap_baddr); end
    step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tests++; if (inst_s2 !== bios_word(12'h040) || pc_s2 !== 32'h4000_0100 || valid_s2 !== 1'b1) begin
      failed++; $display("FAIL stall_release got %h/%h/%b exp %h/40000100/1", inst_s2, pc_s2, valid_s2, bios_word(12'h040)); end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0, 2'd2, 32'h0, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tests++; if (pc_s1 !== 32'h0 || cap_iaddr !== 14'h0) begin failed++; $display("FAIL wrap_pc got %h/%h exp 0/0", pc_s1, cap_iaddr); end
    tests++; if (inst_s2 !== NOP_INST || valid_s2 !== 1'b1 || pc_s2 !== 32'hFFFF_FFFC) begin
      failed++; $display("FAIL wrap_region got %h/%b/%h exp %h/1/fffffffc", inst_s2, valid_s2, pc_s2, NOP_INST); end
  endtask

  task automatic test_misaligned();
    step(1'b0, 1'b0, 2'd2, 32'h0, 32'h4000_0106);
    tests++; if (cap_baddr !== 12'h041 || pc_s1 !== 32'h4000_0106) begin
      failed++; $display("FAIL mis_addr got %h/%h exp 041/40000106", cap_baddr, pc_s1); end
    step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tests++; if (inst_s2 !== bios_word(12'h041) || pc_s2 !== 32'h4000_0106 || pc_s1 !== 32'h4000_010A) begin
      failed++; $display("FAIL mis_fetch got %h/%h/%h exp %h/40000106/4000010a", inst_s2, pc_s2, pc_s1, bios_word(12'h041)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] t;
    for (int i = 0; i < 3; i++) begin
      t = rand_target();
      step(1'b0, 1'($urandom), 2'(1 + (i % 2)), t, t);
      tests++; if (valid_s2 !== 1'b0 || inst_s2 !== NOP_INST || pc_s1 !== t) begin
        failed++; $display("FAIL b2b_%0d got %h/%b/%h exp %h/0/%h", i, inst_s2, valid_s2, pc_s1, NOP_INST, t); end
    end
    step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tests++; if (inst_s2 !== m_word(t) || pc_s2 !== t || valid_s2 !== 1'b1) begin
      failed++; $display("FAIL b2b_land got %h/%h/%b exp %h/%h/1", inst_s2, pc_s2, valid_s2, m_word(t), t); end
  endtask

  task automatic test_reset_mid_redirect();
    step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 2'd1, 32'h0000_0200, 32'h0);
    tests++; if (pc_s1 !== RESET_PC || inst_s2 !== NOP_INST || pc_s2 !== 32'h0 || valid_s2 !== 1'b0) begin
      failed++; $display("FAIL rst_mid got %h/%h/%h/%b exp 40000000/%h/0/0", pc_s1, inst_s2, pc_s2, valid_s2, NOP_INST); end
    tests++; if (fetch_count !== 32'h0 || flush_count !== 32'h0 || cap_baddr !== 12'h0) begin
      failed++; $display("FAIL rst_mid_cnt got %h/%h/%h exp 0/0/0", fetch_count, flush_count, cap_baddr); end
  endtask

  task automatic test_counters();
    step(1'b1, 1'b0, 2'd0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 2'd1, 32'h0000_0040, 32'h0);
    step(1'b0, 1'b0, 2'd2, 32'h0, 32'h4000_0080);
    tests++; if (fetch_count !== (PERF ? 32'd10 : 32'd0)) begin failed++; $display("FAIL fetch_count got %0d exp %0d", fetch_count, PERF ? 10 : 0); end
    tests++; if (flush_count !== (PERF ? 32'd2 : 32'd0)) begin failed++; $display("FAIL flush_count got %0d exp %0d", flush_count, PERF ? 2 : 0); end
  endtask

  task automatic test_random();
    logic r, st;
    logic [1:0] sel;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 3) == 0);
      sel = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      step(r, st, sel, rand_target(), rand_target());
      tests++; if (cap_baddr !== m_baddr || cap_iaddr !== m_iaddr) begin
        failed++; $display("FAIL rnd_addr[%0d] got %h/%h exp %h/%h", i, cap_baddr, cap_iaddr, m_baddr, m_iaddr); end
      tests++; if (pc_s1 !== m_pc || inst_s2 !== m_inst || pc_s2 !== m_s2pc || valid_s2 !== m_vld) begin
        failed++; $display("FAIL rnd_state[%0d] got %h/%h/%h/%b exp %h/%h/%h/%b", i, pc_s1, inst_s2, pc_s2, valid_s2, m_pc, m_inst, m_s2pc, m_vld); end
      tests++; if (fetch_count !== (PERF ? m_fetch : 32'h0) || flush_count !== (PERF ? m_flush : 32'h0)) begin
        failed++; $display("FAIL rnd_cnt[%0d] got %h/%h exp %h/%h", i, fetch_count, flush_count, PERF ? m_fetch : 32'h0, PERF ? m_flush : 32'h0); end
    end
  endtask

  initial begin
    m_pc = RESET_PC; m_inst = NOP_INST; m_s2pc = 32'h0; m_vld = 1'b0;
    m_fetch = 0; m_flush = 0;
    test_reset();
    test_first_fetch();
    test_branch_redirect();
    test_jal_stall();
    test_wrap();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_redirect();
    test_counters();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
